// File: rtl/status_pkg.sv
// Shared types and constants for the status display arbiter.
package status_pkg;

    // Display FSM: IDLE waits for a request, SHOW holds the code, DONE acks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Status codes understood by the sevensegment decoder.
    localparam logic [3:0] OK_CODE   = 4'b1111;
    localparam logic [3:0] FAIL_CODE = 4'b0000;
    localparam logic [3:0] IDLE_CODE = 4'b1010;

endpackage : status_pkg

// File: rtl/status_display_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above the pointer, wrapping.
// Purely combinational; the caller registers the result.
module rr_picker #(
    parameter int NUM_REQ = 3,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     grant_o,
    output logic               any_o
);

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        any_o   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                grant_o = IDW'(idx);
                any_o   = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/status_display_arbiter.sv
// Status display arbiter: shares the result / seven-segment / redlight path
// between several requesters with round-robin grants and a fixed dwell time.
// Optional build macro STATUS_BLINK_EN: blink the fault lamp for non-OK codes
// instead of holding it steady.
module status_display_arbiter
    import status_pkg::*;
#(
    parameter int         NUM_REQ     = 3,
    parameter int         HOLD_CYCLES = 1000,
    parameter logic [3:0] OK_CODE     = status_pkg::OK_CODE,
    parameter logic [3:0] IDLE_CODE   = status_pkg::IDLE_CODE,
    localparam int        IDW         = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_code,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [3:0]           result,
    output logic                 redlight,
    output logic                 busy,
    output logic [IDW-1:0]       active_id
);

    localparam int            CW       = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

`ifdef STATUS_BLINK_EN
    // Lamp toggles every quarter of the dwell time, never faster than 1 cycle.
    localparam int            BLINK_CYC  = (HOLD_CYCLES / 4 < 1) ? 1 : HOLD_CYCLES / 4;
    localparam int            BW         = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    logic [BW-1:0] blink_cnt_q;
    logic          fail_q;
`endif

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       active_q;
    logic [3:0]           result_q;
    logic                 red_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   ack_q;

    logic [NUM_REQ-1:0][3:0] codes;
    logic [IDW-1:0]          pick_idx;
    logic                    pick_any;
    logic [3:0]              pick_code;
    logic [NUM_REQ-1:0]      ack_d;
    logic [IDW-1:0]          ptr_d;

    assign codes = req_code;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    // Code of the winning requester, the ack one-hot and the next rr pointer.
    always_comb begin
        pick_code        = codes[pick_idx];
        ack_d            = '0;
        ack_d[active_q]  = 1'b1;
        ptr_d            = (active_q == IDW'(NUM_REQ - 1)) ? '0 : active_q + IDW'(1);
    end

    // Display FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            active_q    <= '0;
            result_q    <= IDLE_CODE;
            red_q       <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= '0;
`ifdef STATUS_BLINK_EN
            blink_cnt_q <= '0;
            fail_q      <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        // Code is latched here and ignored afterwards.
                        result_q    <= pick_code;
                        active_q    <= pick_idx;
                        red_q       <= (pick_code != OK_CODE);
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= SHOW;
`ifdef STATUS_BLINK_EN
                        blink_cnt_q <= '0;
                        fail_q      <= (pick_code != OK_CODE);
`endif
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        ack_q   <= ack_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`ifdef STATUS_BLINK_EN
                    if (fail_q) begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_q <= '0;
                            red_q       <= ~red_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + BW'(1);
                        end
                    end
`endif
                end
                DONE: begin
                    // Ack was visible this cycle; release the display.
                    state_q  <= IDLE;
                    result_q <= IDLE_CODE;
                    red_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    ptr_q    <= ptr_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack   = ack_q;
    assign result    = result_q;
    assign redlight  = red_q;
    assign busy      = busy_q;
    assign active_id = active_q;

endmodule : status_display_arbiter

// File: tb/tb_status_display_arbiter.sv
// Directed bench for status_display_arbiter with NUM_REQ=3, HOLD_CYCLES=4.
module tb_status_display_arbiter;

    localparam int NR   = 3;
    localparam int HOLD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [4*NR-1:0] req_code;
    logic [NR-1:0] req_ack;
    logic [3:0]    result;
    logic          redlight;
    logic          busy;
    logic [1:0]    active_id;

    int total = 0;
    int bad   = 0;

    status_display_arbiter #(
        .NUM_REQ     (NR),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ack   (req_ack),
        .result    (result),
        .redlight  (redlight),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clock = ~clock;

    // Advance one edge, then settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".result"}, 32'(result), 32'hA);
        chk({tag, ".red"},    32'(redlight), 32'h0);
        chk({tag, ".busy"},   32'(busy), 32'h0);
        chk({tag, ".ack"},    32'(req_ack), 32'h0);
    endtask

    // The request for `id` must already be driven while the DUT is in IDLE.
    // Checks the full 5-cycle display, scrambles the code after the grant,
    // optionally drops valid early, then drops valid after the ack.
    task automatic run_grant(input string tag, input int id, input logic [3:0] code, input bit early);
        logic fail;
        logic exp_red;
        fail = (code != 4'b1111);
        tick();
        for (int c = 0; c < HOLD + 1; c++) begin
`ifdef STATUS_BLINK_EN
            exp_red = fail && (c % 2 == 0);
`else
            exp_red = fail;
`endif
            chk({tag, ".result"}, 32'(result), 32'(code));
            chk({tag, ".id"},     32'(active_id), 32'(id));
            chk({tag, ".busy"},   32'(busy), 32'h1);
            chk({tag, ".red"},    32'(redlight), 32'(exp_red));
            chk({tag, ".ack"},    32'(req_ack), (c == HOLD) ? 32'(1 << id) : 32'h0);
            if (c == 0) begin
                req_code[id*4 +: 4] = ~code;
                if (early) req_valid[id] = 1'b0;
            end
            if (c < HOLD) tick();
        end
        req_valid[id] = 1'b0;
        tick();
        chk_idle({tag, ".after"});
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_code  = '0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset.id", 32'(active_id), 32'h0);
        reset = 1'b0;
        tick();
        chk_idle("idle0");

        // Single OK request from requester 0 (pointer 0 -> 1).
        req_code[3:0] = 4'b1111;
        req_valid     = 3'b001;
        run_grant("ok0", 0, 4'b1111, 1'b0);

        // Fail code from requester 1, valid dropped during SHOW (pointer -> 2).
        req_code[7:4] = 4'b0000;
        req_valid     = 3'b010;
        run_grant("fail1", 1, 4'b0000, 1'b1);

        // Mid-operation reset: grant 2, reset in the 2nd SHOW cycle.
        req_code[11:8] = 4'b0011;
        req_valid      = 3'b100;
        tick();
        chk("mrst.id",   32'(active_id), 32'h2);
        chk("mrst.busy", 32'(busy), 32'h1);
        tick();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        chk_idle("mrst");
        chk("mrst.id0", 32'(active_id), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < HOLD + 1; i++) begin
            tick();
            chk("mrst.noack", 32'(req_ack), 32'h0);
        end

        // Contention with pointer back at 0: order must be 0, 1, 2.
        req_code  = {4'b0101, 4'b1111, 4'b0110};
        req_valid = 3'b111;
        run_grant("cont0", 0, 4'b0110, 1'b0);
        run_grant("cont1", 1, 4'b1111, 1'b0);
        run_grant("cont2", 2, 4'b0101, 1'b0);

        // Fairness: 0 re-requests right away while 1 waits (pointer 0 -> 1).
        req_code  = {4'b0000, 4'b0001, 4'b1111};
        req_valid = 3'b011;
        run_grant("fair0", 0, 4'b1111, 1'b0);
        req_valid[0] = 1'b1;
        req_code[3:0] = 4'b1000;
        run_grant("fair1", 1, 4'b0001, 1'b0);
        run_grant("fair0b", 0, 4'b1000, 1'b0);

        tick();
        chk_idle("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_status_display_arbiter
